// File: rtl/bit_n2t.sv
// bit_n2t: loadable storage register (Hack "Bit"), WIDTH bits wide.
//
// Captures `in` on the rising clk edge when `load` is 1 and holds it otherwise.
// At each edge, reset has priority over load.
//
// Parameters:
//   WIDTH     - stored word width; all data ports are WIDTH bits
//   RESET_VAL - value forced by reset; also the simulation power-up value
//
// Ports (declaration order: in, load, clk, out, reset[, changed]):
//   in      - data to store
//   load    - write enable, sampled on rising clk
//   clk     - rising-edge clock
//   out     - stored value, registered
//   reset   - synchronous, active-high; clears out to RESET_VAL
//   changed - only with BIT_N2T_CHANGED_EN; high for one cycle after a load
//             that altered the stored value
//
// Optional feature macro: BIT_N2T_CHANGED_EN adds the registered `changed` output.
module bit_n2t #(
  parameter int unsigned        WIDTH     = 1,
  parameter logic [WIDTH-1:0]   RESET_VAL = '0
) (
  input  logic [WIDTH-1:0] in,
  input  logic             load,
  input  logic             clk,
  output logic [WIDTH-1:0] out,
  input  logic             reset
`ifdef BIT_N2T_CHANGED_EN
  ,
  output logic             changed
`endif
);

  // The initializer gives the simulation power-up value; hardware relies on
  // reset or a first load.
  logic [WIDTH-1:0] out_q = RESET_VAL;
  logic [WIDTH-1:0] out_d;

  always_comb begin
    out_d = out_q;
    if (load) begin
      out_d = in;
    end
  end

  // A floating (x/z) reset fails the if-test and falls through to normal
  // operation, so only a real 1 resets.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_q <= RESET_VAL;
    end else begin
      out_q <= out_d;
    end
  end

  assign out = out_q;

`ifdef BIT_N2T_CHANGED_EN
  logic changed_q = 1'b0;
  logic changed_d;

  // Compare against the value held before this edge, not the new one.
  always_comb begin
    changed_d = 1'b0;
    if (load && (in != out_q)) begin
      changed_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      changed_q <= 1'b0;
    end else begin
      changed_q <= changed_d;
    end
  end

  assign changed = changed_q;
`endif

endmodule

// File: tb/tb_bit_n2t.sv
// Self-checking bench for bit_n2t: a table of directed vectors on a 1-bit
// instance plus a hand-written sequence on a 4-bit instance.
module tb_bit_n2t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // 1-bit instance, RESET_VAL = 0
  logic in1 = 1'b0;
  logic load1 = 1'b0;
  logic reset1 = 1'b0;
  logic out1;

  // 4-bit instance, RESET_VAL = 5
  logic [3:0] in4 = 4'h0;
  logic       load4 = 1'b0;
  logic       reset4 = 1'b0;
  logic [3:0] out4;
`ifdef BIT_N2T_CHANGED_EN
  logic       chg1;
  logic       chg4;
`endif

  bit_n2t u_dut1 (
    .in     (in1),
    .load   (load1),
    .clk    (clk),
    .out    (out1),
    .reset  (reset1)
`ifdef BIT_N2T_CHANGED_EN
    ,
    .changed(chg1)
`endif
  );

  bit_n2t #(
    .WIDTH    (4),
    .RESET_VAL(4'h5)
  ) u_dut4 (
    .in     (in4),
    .load   (load4),
    .clk    (clk),
    .out    (out4),
    .reset  (reset4)
`ifdef BIT_N2T_CHANGED_EN
    ,
    .changed(chg4)
`endif
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic  rst;
    logic  ld;
    logic  d;
    logic  q;
    string name;
  } vec_t;

  vec_t vecs[12];
  logic prev1 = 1'b0;

  // Drive at negedge, confirm no early update, check after the edge, then
  // wiggle inputs while clk is high and confirm out does not move.
  task automatic apply1(input vec_t v);
    @(negedge clk);
    reset1 = v.rst;
    load1  = v.ld;
    in1    = v.d;
    #1;
    chk({v.name, "_pre"}, {3'b0, out1}, {3'b0, prev1});
    @(posedge clk);
    #1;
    chk({v.name, "_post"}, {3'b0, out1}, {3'b0, v.q});
    #1;
    in1   = ~v.d;
    load1 = ~v.ld;
    #1;
    chk({v.name, "_mid"}, {3'b0, out1}, {3'b0, v.q});
    prev1 = v.q;
  endtask

  logic [3:0] prev4 = 4'h5;

  task automatic apply4(input logic rst, input logic ld, input logic [3:0] d,
                        input logic [3:0] q, input logic chg, input string name);
    @(negedge clk);
    reset4 = rst;
    load4  = ld;
    in4    = d;
    #1;
    chk({name, "_pre"}, out4, prev4);
    @(posedge clk);
    #1;
    chk({name, "_post"}, out4, q);
`ifdef BIT_N2T_CHANGED_EN
    chk({name, "_chg"}, {3'b0, chg4}, {3'b0, chg});
`else
    if (chg) begin
      // changed is not built in this configuration; nothing to compare
    end
`endif
    prev4 = q;
  endtask

  initial begin
    vecs[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, "rst_init"};
    vecs[1]  = '{1'b0, 1'b1, 1'b0, 1'b0, "load0"};
    vecs[2]  = '{1'b0, 1'b0, 1'b1, 1'b0, "hold_in1"};
    vecs[3]  = '{1'b0, 1'b1, 1'b1, 1'b1, "load1"};
    vecs[4]  = '{1'b0, 1'b1, 1'b0, 1'b0, "load0_from1"};
    vecs[5]  = '{1'b0, 1'b0, 1'b0, 1'b0, "hold_a"};
    vecs[6]  = '{1'b0, 1'b0, 1'b1, 1'b0, "hold_b"};
    vecs[7]  = '{1'b0, 1'b1, 1'b1, 1'b1, "load1_again"};
    vecs[8]  = '{1'b1, 1'b1, 1'b1, 1'b0, "rst_over_load"};
    vecs[9]  = '{1'b0, 1'b1, 1'b1, 1'b1, "load1_after_rst"};
    vecs[10] = '{1'b0, 1'b1, 1'b1, 1'b1, "load_same"};
    vecs[11] = '{1'b1, 1'b0, 1'b0, 1'b0, "rst_only"};

    #1;
    chk("powerup1", {3'b0, out1}, 4'h0);
    chk("powerup4", out4, 4'h5);

    for (int i = 0; i < 12; i++) begin
      apply1(vecs[i]);
    end

    // 4-bit: all bits load together, changed flags a differing load only.
    apply4(1'b1, 1'b0, 4'h0, 4'h5, 1'b0, "w4_rst");
    apply4(1'b0, 1'b1, 4'h3, 4'h3, 1'b1, "w4_load3");
    apply4(1'b0, 1'b1, 4'hA, 4'hA, 1'b1, "w4_loadA");
    apply4(1'b0, 1'b1, 4'hA, 4'hA, 1'b0, "w4_loadA_same");
    apply4(1'b0, 1'b0, 4'hF, 4'hA, 1'b0, "w4_hold");
    apply4(1'b0, 1'b1, 4'h0, 4'h0, 1'b1, "w4_load0");
    apply4(1'b1, 1'b1, 4'hF, 4'h5, 1'b0, "w4_rst_over_load");
    apply4(1'b0, 1'b1, 4'h5, 4'h5, 1'b0, "w4_load_rstval");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
